// File: rtl/tmp_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tmp_ctrl_pkg
// Shared types for the TMP register-pair transfer controller.
//   op_e    : operation code as presented on the op port
//   state_e : controller FSM states
//   TMR_W   : width of the per-phase wait counter
// No ports (package).
// -----------------------------------------------------------------------------
package tmp_ctrl_pkg;

  localparam int TMR_W = 8;

  typedef enum logic [1:0] {
    LOAD16    = 2'd0,
    STORE16   = 2'd1,
    ADDR_OUT  = 2'd2,
    ADDR_LOAD = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    ADDR = 3'd3,
    DONE = 3'd4
  } state_e;

  // States in which a transfer is waiting on xfer_ack.
  function automatic logic is_phase(state_e s);
    return (s == HI) || (s == LO) || (s == ADDR);
  endfunction

endpackage

// File: rtl/tmp_ctrl_timer.sv
// -----------------------------------------------------------------------------
// tmp_ctrl_timer
// Per-phase wait counter for tmp_ctrl.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   clear   : restart counting (asserted on the edge that enters a new phase)
//   enable  : a phase is active and waiting
//   limit   : cycles allowed per phase, 0 = never expire
//   expired : the current cycle is the last allowed one; with no ack this
//             edge completes limit waiting cycles
// -----------------------------------------------------------------------------
module tmp_ctrl_timer
  import tmp_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMR_W-1:0] limit,
  output logic             expired
);

  logic [TMR_W-1:0] cnt;

  // Saturating so a disabled timeout never wraps back onto the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds completed waiting cycles, so the count reaches limit on the
  // edge that closes the cycle where cnt == limit-1.
  assign expired = enable && (limit != '0) && (cnt == limit - 1'b1);

endmodule

// File: rtl/tmp_ctrl.sv
// -----------------------------------------------------------------------------
// tmp_ctrl
// Sequences 16-bit loads/stores of the TMPH/TMPL register pair and address
// pass/load operations against a partner that handshakes with xfer_ack.
// Optional feature macro: TMP_CTRL_ADDR_LOAD_EN (enables op ADDR_LOAD; when
// undefined, ADDR_LOAD requests are rejected with an error pulse).
// Parameter TIMEOUT_CYCLES : max cycles per phase waiting for xfer_ack, 0 = off.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start, op         : operation request (sampled in IDLE only) and opcode
//   xfer_ack          : partner accepts/provides current byte or address
//   xfer_req          : a transfer phase is active
//   busy, done, error : status; done/error are single-cycle pulses
//   reg_tmph_*        : TMPH data_dir, pass_data(n), load, out(n)
//   reg_tmpl_*        : TMPL data_dir, pass_data(n), load, out(n)
//   reg_tmp_pass_address (n), reg_tmp_address_dir : address path controls
// -----------------------------------------------------------------------------
module tmp_ctrl
  import tmp_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       xfer_ack,
  output logic       xfer_req,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       reg_tmph_data_dir,
  output logic       reg_tmph_pass_data,
  output logic       reg_tmph_load,
  output logic       reg_tmph_out,
  output logic       reg_tmpl_data_dir,
  output logic       reg_tmpl_pass_data,
  output logic       reg_tmpl_load,
  output logic       reg_tmpl_out,
  output logic       reg_tmp_pass_address,
  output logic       reg_tmp_address_dir
);

  localparam logic [TMR_W-1:0] TMO_LIMIT = TMR_W'(TIMEOUT_CYCLES);

  state_e state_q, state_d;
  op_e    op_q;
  logic   err_q, err_set;
  logic   tmo;

  tmp_ctrl_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_d != state_q),
    .enable  (is_phase(state_q)),
    .limit   (TMO_LIMIT),
    .expired (tmo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= LOAD16;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_set;
      if ((state_q == IDLE) && start) begin
        op_q <= op_e'(op);
      end
    end
  end

  // Ack takes priority over timeout so a late ack still completes the phase.
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op_e'(op))
            LOAD16, STORE16: state_d = HI;
            ADDR_OUT:        state_d = ADDR;
            ADDR_LOAD: begin
`ifdef TMP_CTRL_ADDR_LOAD_EN
              state_d = ADDR;
`else
              err_set = 1'b1;
`endif
            end
            default: state_d = IDLE;
          endcase
        end
      end
      HI: begin
        if (xfer_ack) begin
          state_d = LO;
        end else if (tmo) begin
          state_d = IDLE;
          err_set = 1'b1;
        end
      end
      LO, ADDR: begin
        if (xfer_ack) begin
          state_d = DONE;
        end else if (tmo) begin
          state_d = IDLE;
          err_set = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line drive is decoded from the current state; only the load strobes
  // depend combinationally on xfer_ack.
  always_comb begin
    xfer_req             = is_phase(state_q);
    busy                 = (state_q != IDLE);
    done                 = (state_q == DONE);
    error                = err_q;
    reg_tmph_data_dir    = 1'b0;
    reg_tmph_pass_data   = 1'b1;
    reg_tmph_load        = 1'b0;
    reg_tmph_out         = 1'b1;
    reg_tmpl_data_dir    = 1'b0;
    reg_tmpl_pass_data   = 1'b1;
    reg_tmpl_load        = 1'b0;
    reg_tmpl_out         = 1'b1;
    reg_tmp_pass_address = 1'b1;
    reg_tmp_address_dir  = 1'b0;
    case (state_q)
      HI: begin
        reg_tmph_pass_data = 1'b0;
        if (op_q == LOAD16) begin
          reg_tmph_data_dir = 1'b1;
          reg_tmph_load     = xfer_ack;
        end else begin
          reg_tmph_out = 1'b0;
        end
      end
      LO: begin
        reg_tmpl_pass_data = 1'b0;
        if (op_q == LOAD16) begin
          reg_tmpl_data_dir = 1'b1;
          reg_tmpl_load     = xfer_ack;
        end else begin
          reg_tmpl_out = 1'b0;
        end
      end
      ADDR: begin
        reg_tmp_pass_address = 1'b0;
`ifdef TMP_CTRL_ADDR_LOAD_EN
        if (op_q == ADDR_LOAD) begin
          reg_tmp_address_dir = 1'b1;
          reg_tmph_load       = xfer_ack;
          reg_tmpl_load       = xfer_ack;
        end else begin
          reg_tmph_out = 1'b0;
          reg_tmpl_out = 1'b0;
        end
`else
        reg_tmph_out = 1'b0;
        reg_tmpl_out = 1'b0;
`endif
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_tmp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tmp_ctrl
// Self-checking bench for tmp_ctrl. Two instances share clk/rst: dut_a uses
// the default timeout (16), dut_b uses TIMEOUT_CYCLES=4 for timeout cases.
// Each driven cycle pushes the expected output vector of both instances; a
// monitor pops and compares mid-low-phase of the clock.
// Honours TMP_CTRL_ADDR_LOAD_EN for the ADDR_LOAD expectations.
// -----------------------------------------------------------------------------
module tb_tmp_ctrl;

  typedef struct packed {
    logic xreq, busy, done, err;
    logic hdir, hpass, hload, hout;
    logic ldir, lpass, lload, lout;
    logic paddr, adir;
  } obs_t;

  typedef struct {
    obs_t ea;
    obs_t eb;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, ack_a = 1'b0, start_b = 1'b0, ack_b = 1'b0;
  logic [1:0] op_a = 2'd0, op_b = 2'd0;

  logic a_xreq, a_busy, a_done, a_err, a_hdir, a_hpass, a_hload, a_hout;
  logic a_ldir, a_lpass, a_lload, a_lout, a_paddr, a_adir;
  logic b_xreq, b_busy, b_done, b_err, b_hdir, b_hpass, b_hload, b_hout;
  logic b_ldir, b_lpass, b_lload, b_lout, b_paddr, b_adir;
  obs_t oa, ob;

  assign oa = {a_xreq, a_busy, a_done, a_err, a_hdir, a_hpass, a_hload, a_hout,
               a_ldir, a_lpass, a_lload, a_lout, a_paddr, a_adir};
  assign ob = {b_xreq, b_busy, b_done, b_err, b_hdir, b_hpass, b_hload, b_hout,
               b_ldir, b_lpass, b_lload, b_lout, b_paddr, b_adir};

  always #5 clk = ~clk;

  tmp_ctrl dut_a (
    .clk(clk), .rst(rst), .start(start_a), .op(op_a), .xfer_ack(ack_a),
    .xfer_req(a_xreq), .busy(a_busy), .done(a_done), .error(a_err),
    .reg_tmph_data_dir(a_hdir), .reg_tmph_pass_data(a_hpass),
    .reg_tmph_load(a_hload), .reg_tmph_out(a_hout),
    .reg_tmpl_data_dir(a_ldir), .reg_tmpl_pass_data(a_lpass),
    .reg_tmpl_load(a_lload), .reg_tmpl_out(a_lout),
    .reg_tmp_pass_address(a_paddr), .reg_tmp_address_dir(a_adir)
  );

  tmp_ctrl #(.TIMEOUT_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .op(op_b), .xfer_ack(ack_b),
    .xfer_req(b_xreq), .busy(b_busy), .done(b_done), .error(b_err),
    .reg_tmph_data_dir(b_hdir), .reg_tmph_pass_data(b_hpass),
    .reg_tmph_load(b_hload), .reg_tmph_out(b_hout),
    .reg_tmpl_data_dir(b_ldir), .reg_tmpl_pass_data(b_lpass),
    .reg_tmpl_load(b_lload), .reg_tmpl_out(b_lout),
    .reg_tmp_pass_address(b_paddr), .reg_tmp_address_dir(b_adir)
  );

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_cyc = 0;

  task automatic chk(input string tag, input obs_t got, input obs_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%b want=%b", tag, got, want);
    end
  endtask

  // Expected vectors, field order xreq busy done err | tmph | tmpl | paddr adir
  function automatic obs_t idle_v();
    obs_t v;
    v = '0;
    v.hpass = 1'b1; v.hout = 1'b1;
    v.lpass = 1'b1; v.lout = 1'b1;
    v.paddr = 1'b1;
    return v;
  endfunction

  function automatic obs_t phase_v();
    obs_t v;
    v = idle_v();
    v.busy = 1'b1; v.xreq = 1'b1;
    return v;
  endfunction

  function automatic obs_t hi_load(input logic a);
    obs_t v;
    v = phase_v(); v.hdir = 1'b1; v.hpass = 1'b0; v.hload = a;
    return v;
  endfunction

  function automatic obs_t lo_load(input logic a);
    obs_t v;
    v = phase_v(); v.ldir = 1'b1; v.lpass = 1'b0; v.lload = a;
    return v;
  endfunction

  function automatic obs_t hi_store();
    obs_t v;
    v = phase_v(); v.hpass = 1'b0; v.hout = 1'b0;
    return v;
  endfunction

  function automatic obs_t lo_store();
    obs_t v;
    v = phase_v(); v.lpass = 1'b0; v.lout = 1'b0;
    return v;
  endfunction

  function automatic obs_t addr_out();
    obs_t v;
    v = phase_v(); v.paddr = 1'b0; v.hout = 1'b0; v.lout = 1'b0;
    return v;
  endfunction

`ifdef TMP_CTRL_ADDR_LOAD_EN
  function automatic obs_t addr_load(input logic a);
    obs_t v;
    v = phase_v(); v.paddr = 1'b0; v.adir = 1'b1; v.hload = a; v.lload = a;
    return v;
  endfunction
`endif

  function automatic obs_t done_v();
    obs_t v;
    v = idle_v(); v.busy = 1'b1; v.done = 1'b1;
    return v;
  endfunction

  function automatic obs_t err_v();
    obs_t v;
    v = idle_v(); v.err = 1'b1;
    return v;
  endfunction

  // One cycle of stimulus for the selected instance; the other idles.
  task automatic drv(input bit sel_b, input logic r, input logic s,
                     input logic [1:0] o, input logic a, input obs_t e);
    exp_t x;
    @(negedge clk);
    rst  = r;
    x.ea = idle_v();
    x.eb = idle_v();
    if (sel_b) begin
      start_b = s; op_b = o; ack_b = a;
      start_a = 1'b0; ack_a = 1'b0;
      x.eb = e;
    end else begin
      start_a = s; op_a = o; ack_a = a;
      start_b = 1'b0; ack_b = 1'b0;
      x.ea = e;
    end
    sb.push_back(x);
  endtask

  task automatic cyc_a(input logic s, input logic [1:0] o, input logic a, input obs_t e);
    drv(1'b0, 1'b0, s, o, a, e);
  endtask

  task automatic cyc_b(input logic s, input logic [1:0] o, input logic a, input obs_t e);
    drv(1'b1, 1'b0, s, o, a, e);
  endtask

  task automatic load16_a();
    cyc_a(1'b1, 2'd0, 1'b0, idle_v());
    cyc_a(1'b0, 2'd0, 1'b1, hi_load(1'b1));
    cyc_a(1'b0, 2'd0, 1'b1, lo_load(1'b1));
    cyc_a(1'b0, 2'd0, 1'b0, done_v());
    cyc_a(1'b0, 2'd0, 1'b0, idle_v());
  endtask

  always begin : monitor
    exp_t e;
    @(negedge clk);
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("a_cyc%0d", n_cyc), oa, e.ea);
      chk($sformatf("b_cyc%0d", n_cyc), ob, e.eb);
      n_cyc++;
    end
  end

  initial begin
    @(posedge clk);
    // reset state, then ack outside a phase
    drv(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, idle_v());
    cyc_a(1'b0, 2'd0, 1'b1, idle_v());
    cyc_a(1'b0, 2'd0, 1'b0, idle_v());

    // LOAD16 with immediate acks
    load16_a();

    // STORE16, ack withheld 5 cycles in HI; op changes mid-op are ignored
    cyc_a(1'b1, 2'd1, 1'b0, idle_v());
    for (int i = 0; i < 5; i++) cyc_a(1'b0, 2'd2, 1'b0, hi_store());
    cyc_a(1'b0, 2'd2, 1'b1, hi_store());
    cyc_a(1'b0, 2'd2, 1'b1, lo_store());
    cyc_a(1'b0, 2'd0, 1'b0, done_v());
    cyc_a(1'b0, 2'd0, 1'b0, idle_v());

    // ADDR_OUT minimum latency
    cyc_a(1'b1, 2'd2, 1'b0, idle_v());
    cyc_a(1'b0, 2'd0, 1'b1, addr_out());
    cyc_a(1'b0, 2'd0, 1'b0, done_v());
    cyc_a(1'b0, 2'd0, 1'b0, idle_v());

    // ADDR_OUT timeout with limit 4
    cyc_b(1'b1, 2'd2, 1'b0, idle_v());
    for (int i = 0; i < 4; i++) cyc_b(1'b0, 2'd2, 1'b0, addr_out());
    cyc_b(1'b0, 2'd2, 1'b0, err_v());
    cyc_b(1'b0, 2'd2, 1'b0, idle_v());

    // ack on the last allowed cycle wins over the timeout
    cyc_b(1'b1, 2'd2, 1'b0, idle_v());
    for (int i = 0; i < 3; i++) cyc_b(1'b0, 2'd2, 1'b0, addr_out());
    cyc_b(1'b0, 2'd2, 1'b1, addr_out());
    cyc_b(1'b0, 2'd0, 1'b0, done_v());
    cyc_b(1'b0, 2'd0, 1'b0, idle_v());

    // LOAD16 timing out in LO: no tmpl load strobe, no done
    cyc_b(1'b1, 2'd0, 1'b0, idle_v());
    cyc_b(1'b0, 2'd0, 1'b1, hi_load(1'b1));
    for (int i = 0; i < 4; i++) cyc_b(1'b0, 2'd0, 1'b0, lo_load(1'b0));
    cyc_b(1'b0, 2'd0, 1'b0, err_v());
    cyc_b(1'b0, 2'd0, 1'b0, idle_v());

    // reset during LO of LOAD16, then a clean LOAD16
    cyc_a(1'b1, 2'd0, 1'b0, idle_v());
    cyc_a(1'b0, 2'd0, 1'b1, hi_load(1'b1));
    drv(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, lo_load(1'b0));
    cyc_a(1'b0, 2'd0, 1'b0, idle_v());
    load16_a();

    // op 3
    cyc_a(1'b1, 2'd3, 1'b0, idle_v());
`ifdef TMP_CTRL_ADDR_LOAD_EN
    cyc_a(1'b0, 2'd3, 1'b0, addr_load(1'b0));
    cyc_a(1'b0, 2'd3, 1'b1, addr_load(1'b1));
    cyc_a(1'b0, 2'd3, 1'b0, done_v());
    cyc_a(1'b0, 2'd3, 1'b0, idle_v());
`else
    cyc_a(1'b0, 2'd3, 1'b0, err_v());
    cyc_a(1'b0, 2'd3, 1'b0, idle_v());
`endif

    // start held high: second op begins only from IDLE after done
    cyc_a(1'b1, 2'd1, 1'b0, idle_v());
    cyc_a(1'b1, 2'd1, 1'b1, hi_store());
    cyc_a(1'b1, 2'd1, 1'b1, lo_store());
    cyc_a(1'b1, 2'd1, 1'b0, done_v());
    cyc_a(1'b1, 2'd0, 1'b0, idle_v());
    cyc_a(1'b0, 2'd0, 1'b1, hi_load(1'b1));
    cyc_a(1'b0, 2'd0, 1'b1, lo_load(1'b1));
    cyc_a(1'b0, 2'd0, 1'b0, done_v());
    cyc_a(1'b0, 2'd0, 1'b0, idle_v());

    @(negedge clk);
    #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
